// File: rtl/mcht_enc_if.sv
// Handshake and line bundle for the Manchester transmitter mcht_enc.
interface mcht_enc_if #(
  parameter int pMSG_LEN = 8
);
  logic [pMSG_LEN-1:0] MSG;
  logic                MSG_VLD;
  logic                MSG_RDY;
  logic                TXD;
  logic                BUSY;

  modport master (output MSG, MSG_VLD, input  MSG_RDY, TXD, BUSY);
  modport slave  (input  MSG, MSG_VLD, output MSG_RDY, TXD, BUSY);
endinterface

// File: rtl/mcht_enc.sv
// Manchester transmitter: preamble, LSB-first Manchester bits, idle-high gap.
// Optional even-parity bit after the payload when MCHT_ENC_PARITY_EN is defined.
module mcht_enc #(
  parameter int pMSG_LEN = 8,
  parameter int pHALF    = 4,
  parameter int pIDLE    = 16
) (
  input  logic       CLK100M,
  input  logic       RST_N,
  mcht_enc_if.slave  bus
);
  localparam int HW = (pHALF > 1)    ? $clog2(pHALF)    : 1;
  localparam int GW = $clog2(pIDLE + 1);
  localparam int IW = (pMSG_LEN > 1) ? $clog2(pMSG_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_LO = 3'd1,
    PRE_HI = 3'd2,
    BIT_A  = 3'd3,
    BIT_B  = 3'd4,
`ifdef MCHT_ENC_PARITY_EN
    PAR_A  = 3'd6,
    PAR_B  = 3'd7,
`endif
    GAP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [pMSG_LEN-1:0] sh_q, sh_d;
  logic                txd_q, txd_d;
  logic                half_end;
`ifdef MCHT_ENC_PARITY_EN
  logic                par_q, par_d;
`endif

  assign half_end = (hcnt_q == HW'(pHALF - 1));

  always_ff @(posedge CLK100M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
`ifdef MCHT_ENC_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
`ifdef MCHT_ENC_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state and counters; every half-bit phase shares one counter.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
`ifdef MCHT_ENC_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        gcnt_d = '0;
        idx_d  = '0;
        if (bus.MSG_VLD) begin
          state_d = PRE_LO;
          sh_d    = bus.MSG;
`ifdef MCHT_ENC_PARITY_EN
          par_d   = ^bus.MSG;
`endif
        end
      end
      PRE_LO: begin
        hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
        if (half_end) state_d = PRE_HI;
      end
      PRE_HI: begin
        hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
        if (half_end) state_d = BIT_A;
      end
      BIT_A: begin
        hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
        if (half_end) state_d = BIT_B;
      end
      BIT_B: begin
        hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
        if (half_end) begin
          sh_d = sh_q >> 1;
          if (idx_q < IW'(pMSG_LEN - 1)) begin
            idx_d   = idx_q + IW'(1);
            state_d = BIT_A;
          end else begin
            idx_d   = '0;
            gcnt_d  = '0;
`ifdef MCHT_ENC_PARITY_EN
            state_d = PAR_A;
`else
            state_d = GAP;
`endif
          end
        end
      end
`ifdef MCHT_ENC_PARITY_EN
      PAR_A: begin
        hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
        if (half_end) state_d = PAR_B;
      end
      PAR_B: begin
        hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
        if (half_end) begin
          gcnt_d  = '0;
          state_d = GAP;
        end
      end
`endif
      GAP: begin
        hcnt_d = '0;
        if (gcnt_q == GW'(pIDLE - 1)) begin
          gcnt_d  = '0;
          state_d = IDLE;
        end else begin
          gcnt_d  = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
        gcnt_d  = '0;
        idx_d   = '0;
        sh_d    = '0;
      end
    endcase
  end

  // The line flop is loaded with the level of the state being entered,
  // so TXD changes in the same cycle the state does.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      PRE_LO: txd_d = 1'b0;
      BIT_A:  txd_d = ~sh_d[0];
      BIT_B:  txd_d = sh_d[0];
`ifdef MCHT_ENC_PARITY_EN
      PAR_A:  txd_d = ~par_d;
      PAR_B:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign bus.TXD     = txd_q;
  assign bus.MSG_RDY = (state_q == IDLE);
  assign bus.BUSY    = (state_q != IDLE);
endmodule

// File: tb/tb_mcht_enc.sv
// Scoreboard bench for mcht_enc: expected per-cycle TXD levels are queued at
// accept time and compared every cycle; an empty queue means idle is expected.
module tb_mcht_enc;
  localparam int LEN  = 8;
  localparam int HALF = 4;
  localparam int IDL  = 16;

  logic CLK100M = 1'b0;
  logic RST_N   = 1'b0;

  mcht_enc_if #(.pMSG_LEN(LEN)) bus();

  mcht_enc #(.pMSG_LEN(LEN), .pHALF(HALF), .pIDLE(IDL)) u_dut (
    .CLK100M (CLK100M),
    .RST_N   (RST_N),
    .bus     (bus)
  );

  always #5 CLK100M = ~CLK100M;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];
  bit mon_en = 1'b0;
  int low_run = 0;
  int low_max = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line levels for cycles T0+1 .. end of gap.
  task automatic push_frame(input logic [LEN-1:0] m);
    repeat (HALF) exp_q.push_back(1'b0);
    repeat (HALF) exp_q.push_back(1'b1);
    for (int k = 0; k < LEN; k++) begin
      repeat (HALF) exp_q.push_back(~m[k]);
      repeat (HALF) exp_q.push_back(m[k]);
    end
`ifdef MCHT_ENC_PARITY_EN
    repeat (HALF) exp_q.push_back(~(^m));
    repeat (HALF) exp_q.push_back(^m);
`endif
    repeat (IDL) exp_q.push_back(1'b1);
  endtask

  // Present m; when MSG_RDY is seen high the next edge accepts it.
  task automatic send(input logic [LEN-1:0] m, input bit keep_vld);
    int t;
    @(negedge CLK100M);
    bus.MSG     = m;
    bus.MSG_VLD = 1'b1;
    t = 0;
    while (bus.MSG_RDY !== 1'b1 && t < 300) begin
      @(negedge CLK100M);
      t++;
    end
    chk("accept_wait", {31'b0, t < 300}, 32'd1);
    push_frame(m);
    @(posedge CLK100M);
    #1;
    if (!keep_vld) bus.MSG_VLD = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge CLK100M);
      t++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (3) @(posedge CLK100M);
  endtask

  // Monitor: one sample per cycle, 2 time units after the rising edge.
  initial begin
    bit e;
    forever begin
      @(posedge CLK100M);
      #2;
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("txd", bus.TXD, {31'b0, e});
          chk("rdy_busy", bus.MSG_RDY, 32'd0);
          chk("busy", bus.BUSY, 32'd1);
        end else begin
          chk("txd_idle", bus.TXD, 32'd1);
          chk("rdy_idle", bus.MSG_RDY, 32'd1);
          chk("busy_idle", bus.BUSY, 32'd0);
        end
        if (bus.TXD === 1'b0) low_run++;
        else low_run = 0;
        if (low_run > low_max) low_max = low_run;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MSG     = '0;
    bus.MSG_VLD = 1'b0;
    #12;
    chk("rst_txd", bus.TXD, 32'd1);
    chk("rst_rdy", bus.MSG_RDY, 32'd1);
    chk("rst_busy", bus.BUSY, 32'd0);
    @(negedge CLK100M);
    RST_N  = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(posedge CLK100M);

    send(8'hA5, 1'b0);
    drain();

    // Held-high request: second accept lands right after the first gap.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    drain();

    // Request while busy must be ignored entirely.
    send(8'h3C, 1'b0);
    repeat (20) @(posedge CLK100M);
    @(negedge CLK100M);
    bus.MSG     = 8'hFF;
    bus.MSG_VLD = 1'b1;
    @(negedge CLK100M);
    bus.MSG_VLD = 1'b0;
    drain();

    // Asynchronous reset mid-frame, then a clean frame.
    send(8'h5A, 1'b0);
    repeat (29) @(posedge CLK100M);
    #3;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_txd", bus.TXD, 32'd1);
    chk("midrst_rdy", bus.MSG_RDY, 32'd1);
    chk("midrst_busy", bus.BUSY, 32'd0);
    repeat (2) @(negedge CLK100M);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK100M);
    send(8'hC3, 1'b0);
    drain();

`ifdef MCHT_ENC_PARITY_EN
    send(8'h07, 1'b0);
    drain();
`endif

    for (int i = 0; i < 3; i++) begin
      send(LEN'($urandom), 1'b0);
      drain();
    end

    chk("max_low_run", {31'b0, low_max <= 2 * HALF}, 32'd1);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
